// File: rtl/remote_comm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : remote_comm_pkg
//  Description : Shared types and constants for the remote-control command
//                link: controller state encoding, acknowledge byte values
//                and a width helper for parametrised counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package remote_comm_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Response byte values understood by the remote end
    localparam logic [7:0] C_ACK_BYTE  = 8'hA5;
    localparam logic [7:0] C_NACK_BYTE = 8'h5A;

    // Bits needed to hold n distinct values, never less than one bit
    function automatic int unsigned width_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/remote_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : remote_cmd_ctrl_if
//  Description : Byte-level handshake between the command controller and the
//                UART transceiver (transmit start/done, receive ready/clear).
//  Revision    : 1.0 - initial release
// ============================================================================
interface remote_cmd_ctrl_if;

    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;

    // Controller side
    modport master (
        output trmt,
        output tx_data,
        output clr_rx_rdy,
        input  tx_done,
        input  rx_rdy,
        input  rx_data
    );

    // Transceiver side
    modport slave (
        input  trmt,
        input  tx_data,
        input  clr_rx_rdy,
        output tx_done,
        output rx_rdy,
        output rx_data
    );

endinterface
`default_nettype wire

// File: rtl/resp_timer.sv
`default_nettype none
// ============================================================================
//  Module      : resp_timer
//  Description : Response-wait timer. Cleared on load, counts while enabled
//                and flags expiry in the cycle its count reaches
//                TIMEOUT_CYC-1. TIMEOUT_CYC of zero never expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_timer
    import remote_comm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYC > 0) begin : g_finite
            localparam int               CNT_W    = width_min1(TIMEOUT_CYC + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

            logic [CNT_W-1:0] r_count;

            // Wait counter: cleared on load, advances once per enabled cycle
            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    r_count <= '0;
                end else if (enable) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign expire = enable && (r_count == CNT_LAST);
        end else begin : g_forever
            assign expire = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/remote_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : remote_cmd_ctrl
//  Description : Multi-byte command transmitter with response tracking.
//                Sends an N-byte command MSB-first over the transceiver
//                byte handshake, waits for a one-byte response and resends
//                the whole command on timeout up to MAX_RETRY times.
//  Revision    : 1.0 - initial release
// ============================================================================
module remote_cmd_ctrl
    import remote_comm_pkg::*;
#(
    parameter int         NUM_BYTES   = 2,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         MAX_RETRY   = 2,
    parameter logic [7:0] ACK_BYTE    = C_ACK_BYTE
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  send_cmd,
    input  logic [8*NUM_BYTES-1:0]                cmd,
    output logic                                  busy,
    output logic                                  cmd_sent,
    output logic                                  resp_rdy,
    output logic [7:0]                            resp,
    output logic                                  ack_ok,
    output logic                                  timeout_err,
    output logic [width_min1(MAX_RETRY + 1)-1:0]  retry_cnt,
    remote_cmd_ctrl_if.master                     uart
);

    localparam int               CMD_W    = 8 * NUM_BYTES;
    localparam int               IDX_W    = width_min1(NUM_BYTES);
    localparam int               RTY_W    = width_min1(MAX_RETRY + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CMD_W-1:0]   r_cmd_hold;
    logic [CMD_W-1:0]   r_shreg;
    logic [CMD_W-1:0]   w_shreg_adv;
    logic [IDX_W-1:0]   r_byte_idx;
    logic [RTY_W-1:0]   r_retry_cnt;

    logic               r_cmd_sent;
    logic               r_resp_rdy;
    logic [7:0]         r_resp;
    logic               r_ack_ok;
    logic               r_timeout_err;

    logic               w_start;
    logic               w_advance;
    logic               w_last_done;
    logic               w_capture;
    logic               w_retry;
    logic               w_give_up;
    logic               w_trmt;
    logic               w_clr_rx;
    logic [7:0]         w_tx_data;
    logic               w_timer_en;
    logic               w_timer_expire;

    assign w_timer_en = (r_state == ST_RESP);

    resp_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_resp_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_last_done),
        .enable (w_timer_en),
        .expire (w_timer_expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake strobes and the byte presented with each trmt
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_advance   = 1'b0;
        w_last_done = 1'b0;
        w_capture   = 1'b0;
        w_retry     = 1'b0;
        w_give_up   = 1'b0;
        w_trmt      = 1'b0;
        w_clr_rx    = 1'b0;
        w_shreg_adv = r_shreg << 8;
        w_tx_data   = r_shreg[CMD_W-1 -: 8];

        case (r_state)
            ST_IDLE: begin
                // First byte goes out straight from the command input
                w_tx_data = cmd[CMD_W-1 -: 8];
                if (send_cmd) begin
                    w_start     = 1'b1;
                    w_trmt      = 1'b1;
                    w_state_nxt = ST_TX;
                end
            end
            ST_TX: begin
                // Anything received before the command is complete is stale
                w_clr_rx = uart.rx_rdy;
                if (uart.tx_done) begin
                    if (r_byte_idx == IDX_LAST) begin
                        w_last_done = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_advance = 1'b1;
                        w_trmt    = 1'b1;
                        w_tx_data = w_shreg_adv[CMD_W-1 -: 8];
                    end
                end
            end
            ST_RESP: begin
                // A retry restarts from the held copy of the command
                w_tx_data = r_cmd_hold[CMD_W-1 -: 8];
                if (uart.rx_rdy) begin
                    w_capture   = 1'b1;
                    w_clr_rx    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_timer_expire) begin
                    if (r_retry_cnt < RTY_MAX) begin
                        w_retry     = 1'b1;
                        w_trmt      = 1'b1;
                        w_state_nxt = ST_TX;
                    end else begin
                        w_give_up   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // No handshake activity while reset is held
        if (!rst_n) begin
            w_trmt   = 1'b0;
            w_clr_rx = 1'b0;
        end
    end

    // Command shift register, byte index and retry counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_hold  <= '0;
            r_shreg     <= '0;
            r_byte_idx  <= '0;
            r_retry_cnt <= '0;
        end else if (w_start) begin
            r_cmd_hold  <= cmd;
            r_shreg     <= cmd;
            r_byte_idx  <= '0;
            r_retry_cnt <= '0;
        end else if (w_advance) begin
            r_shreg     <= w_shreg_adv;
            r_byte_idx  <= r_byte_idx + 1'b1;
        end else if (w_retry) begin
            r_shreg     <= r_cmd_hold;
            r_byte_idx  <= '0;
            r_retry_cnt <= r_retry_cnt + 1'b1;
        end
    end

    // Sticky status flags and captured response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_sent    <= 1'b0;
            r_resp_rdy    <= 1'b0;
            r_resp        <= 8'h00;
            r_ack_ok      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_cmd_sent    <= 1'b0;
                r_resp_rdy    <= 1'b0;
                r_ack_ok      <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (w_last_done) begin
                r_cmd_sent <= 1'b1;
            end
            if (w_retry) begin
                r_cmd_sent <= 1'b0;
            end
            if (w_capture) begin
                r_resp     <= uart.rx_data;
                r_ack_ok   <= (uart.rx_data == ACK_BYTE);
                r_resp_rdy <= 1'b1;
            end
            if (w_give_up) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign busy            = (r_state != ST_IDLE);
    assign cmd_sent        = r_cmd_sent;
    assign resp_rdy        = r_resp_rdy;
    assign resp            = r_resp;
    assign ack_ok          = r_ack_ok;
    assign timeout_err     = r_timeout_err;
    assign retry_cnt       = r_retry_cnt;

    assign uart.trmt       = w_trmt;
    assign uart.tx_data    = w_tx_data;
    assign uart.clr_rx_rdy = w_clr_rx;

endmodule
`default_nettype wire

// File: tb/tb_remote_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_remote_cmd_ctrl
//  Description : Self-checking bench for remote_cmd_ctrl with a three-byte
//                command, 50-cycle response timeout and two retries. A
//                transceiver stand-in answers trmt with tx_done after a
//                random latency; expected bytes, flags and timing come from
//                a per-command model of attempts and responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_cmd_ctrl;

    localparam int         NUM_BYTES   = 3;
    localparam int         TIMEOUT_CYC = 50;
    localparam int         MAX_RETRY   = 2;
    localparam logic [7:0] ACK         = 8'hA5;
    localparam int         CMD_W       = 8 * NUM_BYTES;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             send_cmd;
    logic [CMD_W-1:0] cmd;
    logic             busy;
    logic             cmd_sent;
    logic             resp_rdy;
    logic [7:0]       resp;
    logic             ack_ok;
    logic             timeout_err;
    logic [1:0]       retry_cnt;

    int               checks = 0;
    int               errors = 0;
    logic [7:0]       m_resp;
    logic             m_ack;

    remote_cmd_ctrl_if u_if ();

    remote_cmd_ctrl #(
        .NUM_BYTES   (NUM_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_RETRY   (MAX_RETRY),
        .ACK_BYTE    (ACK)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .send_cmd    (send_cmd),
        .cmd         (cmd),
        .busy        (busy),
        .cmd_sent    (cmd_sent),
        .resp_rdy    (resp_rdy),
        .resp        (resp),
        .ack_ok      (ack_ok),
        .timeout_err (timeout_err),
        .retry_cnt   (retry_cnt),
        .uart        (u_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},        busy,            0);
        chk({tag, "_cmd_sent"},    cmd_sent,        0);
        chk({tag, "_resp_rdy"},    resp_rdy,        0);
        chk({tag, "_ack_ok"},      ack_ok,          0);
        chk({tag, "_timeout_err"}, timeout_err,     0);
        chk({tag, "_resp"},        resp,            0);
        chk({tag, "_retry_cnt"},   retry_cnt,       0);
        chk({tag, "_trmt"},        u_if.trmt,       0);
        chk({tag, "_clr_rx_rdy"},  u_if.clr_rx_rdy, 0);
    endtask

    // One command end to end. resp_att is the attempt (0-based) that gets a
    // reply rdelay cycles after its last tx_done; a value above MAX_RETRY
    // means the remote end never answers.
    task automatic run_cmd(input logic [CMD_W-1:0] c, input int resp_att, input logic [7:0] rbyte,
                           input int rdelay, input bit stale, input bit busy_send);
        logic [7:0] exp_q[$];
        bit         answered;
        int         n_att;
        bit         flight   = 1'b0;
        int         dcnt     = 0;
        int         attempt  = 0;
        int         nbytes   = 0;
        int         ridx     = -1;
        bit         finished = 1'b0;
        bit         exp_trmt;

        answered = (resp_att <= MAX_RETRY);
        n_att    = answered ? resp_att + 1 : MAX_RETRY + 1;
        for (int a = 0; a < n_att; a++) begin
            for (int b = NUM_BYTES - 1; b >= 0; b--) begin
                exp_q.push_back(c[8*b +: 8]);
            end
        end

        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge clk);
            send_cmd     = (cyc == 0) || (busy_send && (cyc == 2 || cyc == 7));
            cmd          = (cyc == 0) ? c : CMD_W'($urandom);
            u_if.tx_done = flight && (dcnt == 0);
            if (ridx >= 0 && attempt == resp_att && ridx == rdelay) begin
                u_if.rx_rdy  = 1'b1;
                u_if.rx_data = rbyte;
            end else if (stale && flight && dcnt == 1) begin
                u_if.rx_rdy  = 1'b1;
                u_if.rx_data = 8'hFF;
            end else begin
                u_if.rx_rdy  = 1'b0;
                u_if.rx_data = 8'($urandom);
            end
            #1;

            chk("busy", busy, (cyc > 0));
            if (cyc > 0) begin
                chk("cmd_sent", cmd_sent, (ridx >= 0));
                chk("retry_cnt", retry_cnt, attempt);
                chk("resp_rdy_while_busy", resp_rdy, 0);
                chk("timeout_err_while_busy", timeout_err, 0);
            end
            chk("clr_rx_rdy", u_if.clr_rx_rdy, u_if.rx_rdy);

            exp_trmt = (cyc == 0)
                    || (u_if.tx_done && ((nbytes + 1) % NUM_BYTES != 0))
                    || (ridx == TIMEOUT_CYC - 1 && !u_if.rx_rdy && attempt < MAX_RETRY);
            chk("trmt", u_if.trmt, exp_trmt);

            if (ridx >= 0) begin
                if (u_if.rx_rdy) begin
                    finished = 1'b1;
                end else if (ridx == TIMEOUT_CYC - 1) begin
                    if (attempt < MAX_RETRY) begin
                        attempt++;
                        ridx = -1;
                    end else begin
                        finished = 1'b1;
                    end
                end else begin
                    ridx++;
                end
            end

            if (u_if.tx_done) begin
                flight = 1'b0;
                nbytes++;
                if (nbytes % NUM_BYTES == 0) begin
                    ridx = 0;
                end
            end else if (flight) begin
                dcnt--;
            end

            if (u_if.trmt) begin
                if (exp_q.size() > 0) begin
                    chk("tx_data", u_if.tx_data, exp_q.pop_front());
                end else begin
                    chk("tx_extra_byte", u_if.trmt, 0);
                end
                flight = 1'b1;
                dcnt   = $urandom_range(1, 12);
            end
        end
        chk("cmd_cycle_budget", finished, 1);

        @(negedge clk);
        send_cmd     = 1'b0;
        u_if.tx_done = 1'b0;
        u_if.rx_rdy  = 1'b0;
        #1;
        if (answered) begin
            m_resp = rbyte;
            m_ack  = (rbyte == ACK);
        end else begin
            m_ack  = 1'b0;
        end
        chk("end_busy",        busy,            0);
        chk("end_cmd_sent",    cmd_sent,        1);
        chk("end_resp_rdy",    resp_rdy,        answered);
        chk("end_timeout_err", timeout_err,     !answered);
        chk("end_retry_cnt",   retry_cnt,       n_att - 1);
        chk("end_resp",        resp,            m_resp);
        chk("end_ack_ok",      ack_ok,          m_ack);
        chk("end_trmt",        u_if.trmt,       0);
        chk("end_clr_rx_rdy",  u_if.clr_rx_rdy, 0);
        chk("end_bytes_left",  exp_q.size(),    0);
    endtask

    // Reset lands between the first and second byte of a command
    task automatic reset_mid();
        @(negedge clk);
        cmd      = CMD_W'($urandom);
        send_cmd = 1'b1;
        #1;
        chk("rst_seq_trmt_first", u_if.trmt, 1);
        @(negedge clk);
        send_cmd = 1'b0;
        repeat (2) @(negedge clk);
        u_if.tx_done = 1'b1;
        #1;
        chk("rst_seq_trmt_second", u_if.trmt, 1);
        @(negedge clk);
        u_if.tx_done = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_state("rst_mid");
        @(negedge clk);
        u_if.tx_done = 1'b1;
        #1;
        chk("rst_mid_no_trmt", u_if.trmt, 0);
        @(negedge clk);
        u_if.tx_done = 1'b0;
        #1;
        chk("rst_mid_idle", busy, 0);
        m_resp = 8'h00;
        m_ack  = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        send_cmd     = 1'b0;
        cmd          = '0;
        u_if.tx_done = 1'b0;
        u_if.rx_rdy  = 1'b0;
        u_if.rx_data = 8'h00;
        m_resp       = 8'h00;
        m_ack        = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk_reset_state("por");
        rst_n = 1'b1;

        // Three-byte command answered with NACK
        run_cmd(24'hABCDEF, 0, 8'h5A, 5, 1'b0, 1'b0);
        // Random command answered with ACK
        run_cmd(CMD_W'($urandom), 0, ACK, $urandom_range(0, TIMEOUT_CYC - 1), 1'b0, 1'b0);
        // Never answered: three full attempts, then timeout
        run_cmd(CMD_W'($urandom), MAX_RETRY + 1, 8'h00, 0, 1'b0, 1'b0);
        // First attempt times out, retry answered
        run_cmd(CMD_W'($urandom), 1, 8'($urandom), $urandom_range(0, TIMEOUT_CYC - 1), 1'b0, 1'b0);
        // Reply in the very cycle the timer expires wins over the retry
        run_cmd(CMD_W'($urandom), 0, 8'h3C, TIMEOUT_CYC - 1, 1'b0, 1'b0);
        // Last allowed attempt answered at the expiry cycle
        run_cmd(CMD_W'($urandom), MAX_RETRY, ACK, TIMEOUT_CYC - 1, 1'b0, 1'b0);
        // Stale receive bytes during TX and send_cmd pulses while busy
        run_cmd(24'h123456, 0, ACK, 3, 1'b1, 1'b1);
        // Reset between bytes, then a normal command
        reset_mid();
        run_cmd(CMD_W'($urandom), 0, ACK, 10, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_cmd(CMD_W'($urandom), int'($urandom_range(0, MAX_RETRY + 1)),
                    ($urandom_range(0, 1) != 0) ? ACK : 8'($urandom),
                    int'($urandom_range(0, TIMEOUT_CYC - 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
